apb_bridge_multislot: RTL and testbench

- Parametrised AHB-Lite to APB3 bridge, successor to the fixed 16-slot BFM bridge; sits between the BFM/AHB master and APB peripherals in testbenches and in the SoC fabric.
- Adds configurable slot count and decode position, an APB2-compatibility mode, a PREADY timeout with error response, and a decode error for unmapped slots.
- Handles single AHB transfers only; each AHB transfer maps to exactly one APB transfer.

---
 rtl/apb_bridge_multislot.sv | 191 +++++++++++++++++++
 tb/tb_apb_bridge_multislot.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_multislot.sv
// rtl/apb_bridge_multislot.sv - AHB-Lite to APB3 bridge with parametrised slot decode,
// PREADY timeout abort and decode-error response for unmapped slots (single transfers only).
module apb_bridge_multislot #(
  parameter int NUM_SLOTS  = 16,
  parameter int SLOT_LSB   = 24,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int APB3_EN    = 1,
  parameter int TIMEOUT    = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [NUM_SLOTS-1:0]  PSEL,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  TIMEOUT_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [3:0]              slot_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_SLOTS-1:0]    sel_onehot;
  logic [3:0]              slot_in;
  logic                    slot_ok;
  logic                    req;
  logic                    accept;
  logic                    pready_eff;
  logic                    pslverr_eff;
  logic                    timeout_hit;
  logic                    unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // In APB2-compatible mode every access completes in its first ACCESS cycle without error.
  assign pready_eff  = (APB3_EN != 0) ? PREADY  : 1'b1;
  assign pslverr_eff = (APB3_EN != 0) ? PSLVERR : 1'b0;

  assign slot_in = HADDR[SLOT_LSB+3:SLOT_LSB];
  assign slot_ok = ({1'b0, slot_in} < 5'(NUM_SLOTS));
  assign req     = HSEL & HREADYIN & HTRANS[1];
  assign accept  = req & ((state_q == S_IDLE) | (state_q == S_ERR2));

  assign timeout_hit = (TIMEOUT != 0) && (state_q == S_ACCESS) && !pready_eff
                       && (cnt_q == CNT_LAST);

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sel_onehot[i] = (slot_q == 4'(i));
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      S_IDLE, S_ERR2: begin
        HRESP = (state_q == S_ERR2);
        if (accept) begin
          state_d = slot_ok ? S_LATCH : S_ERR1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        HREADYOUT = 1'b0;
        state_d   = S_SETUP;
      end
      S_SETUP: begin
        HREADYOUT = 1'b0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        HREADYOUT = 1'b0;
        if (pready_eff) begin
          state_d = pslverr_eff ? S_ERR1 : S_IDLE;
        end else if (timeout_hit) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      addr_q      <= '0;
      write_q     <= 1'b0;
      slot_q      <= '0;
      cnt_q       <= '0;
      HRDATA      <= '0;
      PSEL        <= '0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PENABLE     <= 1'b0;
      PWDATA      <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      TIMEOUT_ERR <= 1'b0;
      if (accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        slot_q  <= slot_in;
      end
      // Wait-state counter only runs while a slave is stalling an access.
      if ((state_q == S_ACCESS) && !pready_eff && !timeout_hit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
      case (state_q)
        S_LATCH: begin
          PADDR  <= addr_q;
          PWRITE <= write_q;
          PSEL   <= sel_onehot;
          if (write_q) begin
            PWDATA <= HWDATA;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
        end
        S_ACCESS: begin
          if (pready_eff) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            if (!PWRITE) begin
              HRDATA <= PRDATA;
            end
          end else if (timeout_hit) begin
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            TIMEOUT_ERR <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  psel_onehot_a: assert property (@(posedge HCLK) disable iff (!HRESETN) $onehot0(PSEL));
  penable_psel_a: assert property (@(posedge HCLK) disable iff (!HRESETN)
                                   PENABLE |-> (PSEL != '0));

endmodule

// File: tb/tb_apb_bridge_multislot.sv
// tb/tb_apb_bridge_multislot.sv - scoreboard bench for apb_bridge_multislot:
// instance 0 is APB3 with 6 slots and TIMEOUT=8, instance 1 is APB2-compatible with 16 slots.
module tb_apb_bridge_multislot;

  localparam int TMO = 8;

  typedef struct {
    bit          err;
    int          low;
    bit          tmo;
    logic [31:0] rdata;
  } ahb_exp_t;

  typedef struct {
    int          wt;
    bit          er;
    logic [31:0] rd;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    int          slot;
  } apb_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel      [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [31:0] haddr     [2];
  logic [31:0] hwdata    [2];
  logic        hreadyin  [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];
  logic [31:0] paddr     [2];
  logic        pwrite    [2];
  logic        penable   [2];
  logic [31:0] pwdata    [2];
  logic [31:0] prdata    [2];
  logic        pready    [2];
  logic        pslverr   [2];
  logic        tmo_err   [2];
  logic [5:0]  psel_a;
  logic [15:0] psel_b;

  ahb_exp_t    exp_q  [2][$];
  apb_exp_t    slv_q  [2][$];
  apb_exp_t    apbx_q [2][$];
  logic [31:0] last_rd [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  apb_bridge_multislot #(.NUM_SLOTS(6), .SLOT_LSB(24), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                         .APB3_EN(1), .TIMEOUT(TMO)) dut_a (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel[0]), .HTRANS(htrans[0]), .HWRITE(hwrite[0]),
    .HADDR(haddr[0]), .HWDATA(hwdata[0]), .HREADYIN(hreadyin[0]), .HREADYOUT(hreadyout[0]),
    .HRESP(hresp[0]), .HRDATA(hrdata[0]), .PSEL(psel_a), .PADDR(paddr[0]), .PWRITE(pwrite[0]),
    .PENABLE(penable[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .TIMEOUT_ERR(tmo_err[0])
  );

  apb_bridge_multislot #(.NUM_SLOTS(16), .SLOT_LSB(24), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                         .APB3_EN(0), .TIMEOUT(TMO)) dut_b (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel[1]), .HTRANS(htrans[1]), .HWRITE(hwrite[1]),
    .HADDR(haddr[1]), .HWDATA(hwdata[1]), .HREADYIN(hreadyin[1]), .HREADYOUT(hreadyout[1]),
    .HRESP(hresp[1]), .HRDATA(hrdata[1]), .PSEL(psel_b), .PADDR(paddr[1]), .PWRITE(pwrite[1]),
    .PENABLE(penable[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .TIMEOUT_ERR(tmo_err[1])
  );

  function automatic int nslots(input int d);
    return (d == 0) ? 6 : 16;
  endfunction

  function automatic bit apb3(input int d);
    return (d == 0);
  endfunction

  function automatic logic [15:0] psel_of(input int d);
    return (d == 0) ? {10'b0, psel_a} : psel_b;
  endfunction

  function automatic bit coin();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic string nm(input string s, input int d);
    return $sformatf("%s[%0d]", s, d);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_reset(input int d);
    check(nm("rst_hreadyout", d), 64'(hreadyout[d]), 64'(1));
    check(nm("rst_hresp", d), 64'(hresp[d]), 64'(0));
    check(nm("rst_hrdata", d), 64'(hrdata[d]), 64'(0));
    check(nm("rst_psel", d), 64'(psel_of(d)), 64'(0));
    check(nm("rst_penable", d), 64'(penable[d]), 64'(0));
    check(nm("rst_pwrite", d), 64'(pwrite[d]), 64'(0));
    check(nm("rst_paddr", d), 64'(paddr[d]), 64'(0));
    check(nm("rst_pwdata", d), 64'(pwdata[d]), 64'(0));
    check(nm("rst_timeout_err", d), 64'(tmo_err[d]), 64'(0));
  endtask

  // Reference model: outcome of one transfer computed from slot map, wait count and error flag.
  task automatic issue(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int wt, input bit er,
                       input logic [31:0] rd);
    ahb_exp_t e;
    apb_exp_t a;
    int       slot;
    int       w;
    bit       ee;
    bit       rdy;
    int       guard;
    slot  = int'(addr[27:24]);
    w     = apb3(d) ? wt : 0;
    ee    = apb3(d) ? er : 1'b0;
    e.tmo = 1'b0;
    if (slot >= nslots(d)) begin
      e.err = 1'b1;
      e.low = 1;
    end else begin
      a.wt = w; a.er = ee; a.rd = rd; a.addr = addr; a.wr = wr; a.wdata = wdata; a.slot = slot;
      slv_q[d].push_back(a);
      apbx_q[d].push_back(a);
      if (apb3(d) && w >= TMO) begin
        e.err = 1'b1;
        e.low = TMO + 3;
        e.tmo = 1'b1;
      end else begin
        e.err = ee;
        e.low = 3 + w + (ee ? 1 : 0);
        if (!wr) last_rd[d] = rd;
      end
    end
    e.rdata = last_rd[d];
    exp_q[d].push_back(e);
    hsel[d]     = 1'b1;
    htrans[d]   = coin() ? 2'b11 : 2'b10;
    hwrite[d]   = wr;
    haddr[d]    = addr;
    hreadyin[d] = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      rdy = hreadyout[d];
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 300);
    check(nm("accept", d), 64'(rdy), 64'(1));
    hwdata[d] = wdata;
    htrans[d] = 2'b00;
    hsel[d]   = coin();
  endtask

  task automatic idle_cycles(input int d, input int n);
    repeat (n) begin
      case ($urandom_range(0, 3))
        0: begin hsel[d] = 1'b1; htrans[d] = 2'b00; end
        1: begin hsel[d] = 1'b1; htrans[d] = 2'b01; end
        2: begin hsel[d] = 1'b0; htrans[d] = 2'b10; end
        default: begin hsel[d] = 1'b1; htrans[d] = 2'b10; hreadyin[d] = 1'b0; end
      endcase
      haddr[d]  = $urandom;
      hwrite[d] = coin();
      @(posedge clk);
      #1;
      hreadyin[d] = 1'b1;
    end
    hreadyin[d] = 1'b1;
    htrans[d]   = 2'b00;
  endtask

  task automatic rand_xfer(input int d);
    int          slot;
    int          r;
    int          wt;
    logic [31:0] addr;
    slot = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                       : int'($urandom_range(0, nslots(d) - 1));
    addr = $urandom;
    addr[27:24] = 4'(slot);
    r = int'($urandom_range(0, 9));
    if (r < 6) wt = 0;
    else if (r < 8) wt = int'($urandom_range(1, 3));
    else wt = int'($urandom_range(6, 10));
    issue(d, coin(), addr, $urandom, wt, ($urandom_range(0, 5) == 0), $urandom);
  endtask

  task automatic slave(input int d);
    apb_exp_t cur;
    int       acc = 0;
    bit       act = 1'b0;
    bit       rdy;
    forever begin
      @(posedge clk);
      #1;
      if (psel_of(d) != 0 && !penable[d]) begin
        act = (slv_q[d].size() > 0);
        if (act) cur = slv_q[d].pop_front();
        acc = 0;
      end
      if (act && psel_of(d) != 0 && penable[d]) begin
        rdy = (acc >= cur.wt);
        acc++;
        prdata[d] = rdy ? cur.rd : $urandom;
        if (apb3(d)) begin
          pready[d]  = rdy;
          pslverr[d] = rdy ? cur.er : coin();
        end else begin
          pready[d]  = ($urandom_range(0, 3) == 0);
          pslverr[d] = ($urandom_range(0, 3) != 0);
        end
      end else begin
        pready[d]  = coin();
        pslverr[d] = coin();
        prdata[d]  = $urandom;
      end
    end
  endtask

  task automatic mon_ahb(input int d);
    ahb_exp_t e;
    bit       inph = 1'b0;
    int       low = 0;
    int       tmo = 0;
    bit       last_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inph = 1'b0;
        continue;
      end
      if (inph) begin
        if (tmo_err[d]) tmo++;
        if (!hreadyout[d]) begin
          low++;
          last_resp = hresp[d];
          if (low > 400) begin
            check(nm("hready_stuck", d), 64'(low), 64'(400));
            inph = 1'b0;
          end
        end else begin
          if (exp_q[d].size() == 0) begin
            check(nm("unexpected_resp", d), 64'(exp_q[d].size()), 64'(1));
          end else begin
            e = exp_q[d].pop_front();
            check(nm("hresp", d), 64'(hresp[d]), 64'(e.err));
            check(nm("hready_low", d), 64'(low), 64'(e.low));
            check(nm("hrdata", d), 64'(hrdata[d]), 64'(e.rdata));
            check(nm("timeout_err", d), 64'(tmo), 64'(e.tmo));
            check(nm("apb_released", d), 64'({psel_of(d), penable[d]}), 64'(0));
            if (e.err) check(nm("err_first", d), 64'(last_resp), 64'(1));
          end
          inph = 1'b0;
        end
      end else begin
        check(nm("idle_ready", d), 64'({hreadyout[d], hresp[d], tmo_err[d]}), 64'(3'b100));
      end
      if (hsel[d] && hreadyin[d] && htrans[d][1] && hreadyout[d]) begin
        inph = 1'b1; low = 0; tmo = 0; last_resp = 1'b0;
      end
    end
  endtask

  task automatic mon_apb(input int d);
    apb_exp_t    a;
    bit          have = 1'b0;
    logic [15:0] ps;
    logic [15:0] one;
    forever begin
      @(negedge clk);
      ps = psel_of(d);
      if (!rst_n) begin
        have = 1'b0;
        continue;
      end
      if (ps != 0) begin
        check(nm("psel_onehot", d), 64'($onehot(ps)), 64'(1));
        if (!penable[d]) begin
          if (apbx_q[d].size() == 0) begin
            check(nm("apb_unexpected", d), 64'(ps), 64'(0));
            have = 1'b0;
          end else begin
            a = apbx_q[d].pop_front();
            have = 1'b1;
            one = 16'h0001;
            check(nm("psel", d), 64'(ps), 64'(one << a.slot));
            check(nm("paddr", d), 64'(paddr[d]), 64'(a.addr));
            check(nm("pwrite", d), 64'(pwrite[d]), 64'(a.wr));
            if (a.wr) check(nm("pwdata", d), 64'(pwdata[d]), 64'(a.wdata));
          end
        end else if (have) begin
          check(nm("access_stable", d), 64'({ps, paddr[d], pwrite[d]}),
                64'({one << a.slot, a.addr, a.wr}));
          if (a.wr) check(nm("pwdata_stable", d), 64'(pwdata[d]), 64'(a.wdata));
        end else begin
          check(nm("access_no_setup", d), 64'(penable[d]), 64'(0));
        end
      end else begin
        check(nm("penable_no_psel", d), 64'(penable[d]), 64'(0));
      end
    end
  endtask

  initial slave(0);
  initial slave(1);
  initial mon_ahb(0);
  initial mon_ahb(1);
  initial mon_apb(0);
  initial mon_apb(1);

  initial begin
    int guard;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0; haddr[d] = '0;
      hwdata[d] = '0; hreadyin[d] = 1'b1; last_rd[d] = '0;
      prdata[d] = '0; pready[d] = 1'b0; pslverr[d] = 1'b0;
    end
    #12;
    check_reset(0);
    check_reset(1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(0, 2);

    issue(0, 1'b1, 32'h0300_0010, 32'hA5A5_1234, 0, 1'b0, 32'h0);
    idle_cycles(0, 2);
    issue(0, 1'b0, 32'h0500_0000, 32'h0, 4, 1'b0, 32'hDEAD_BEEF);
    idle_cycles(0, 2);
    issue(0, 1'b1, 32'h0100_0020, 32'h1234_5678, 0, 1'b1, 32'h0);
    idle_cycles(0, 2);
    issue(0, 1'b0, 32'h0700_0000, 32'h0, 0, 1'b0, 32'h1111_1111);
    idle_cycles(0, 2);
    issue(0, 1'b0, 32'h0200_0004, 32'h0, 20, 1'b0, 32'h2222_2222);
    idle_cycles(0, 2);
    issue(0, 1'b1, 32'h0200_0008, 32'h0000_3333, TMO - 1, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h0900_0000, 32'h0, 0, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h0400_0000, 32'h0, 0, 1'b0, 32'h4444_4444);
    idle_cycles(0, 3);

    for (int i = 0; i < 150; i++) begin
      rand_xfer(0);
      idle_cycles(0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    idle_cycles(0, 4);

    issue(1, 1'b1, 32'h0300_0010, 32'hA5A5_1234, 0, 1'b0, 32'h0);
    issue(1, 1'b0, 32'h0F00_0000, 32'h0, 5, 1'b1, 32'h5555_AAAA);
    idle_cycles(1, 3);
    for (int i = 0; i < 60; i++) begin
      rand_xfer(1);
      idle_cycles(1, int'($urandom_range(0, 2)));
    end
    idle_cycles(1, 4);

    // Reset while an access is stalled: no completion, outputs return to reset values at once.
    issue(0, 1'b1, 32'h0200_0040, 32'hCAFE_F00D, 6, 1'b0, 32'h0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!penable[0] && guard < 20);
    check("reset_test_access", 64'(penable[0]), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check_reset(0);
    check_reset(1);
    exp_q[0].delete();
    slv_q[0].delete();
    apbx_q[0].delete();
    last_rd[0] = '0;
    hsel[0] = 1'b0;
    htrans[0] = 2'b00;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(0, 2);
    issue(0, 1'b1, 32'h0000_0100, 32'h0BAD_CAFE, 1, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h0100_0100, 32'h0, 2, 1'b0, 32'h7777_8888);
    idle_cycles(0, 2);

    guard = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && guard < 500) begin
      idle_cycles(0, 1);
      guard++;
    end
    check("drain", 64'(exp_q[0].size() + exp_q[1].size()), 64'(0));
    idle_cycles(0, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
